alu_uart_ctrl: RTL and testbench
================================

# alu_uart_ctrl

Sequencing controller that feeds the combinational ALU from a byte stream and returns its result. It sits between the UART receiver/transmitter pair and the ALU. It collects three received bytes in order (operand A, operand B, opcode) and drives them as registered ALU inputs. It then captures the ALU result and hands it to the UART transmitter with a start/done handshake.

## Interface
- N, 8, operand/result width; also the UART byte width
- N_op, 6, opcode width; the low N_op bits of the opcode byte

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- rx_data  in  N  received byte; valid only while rx_done=1
- rx_done  in  1  one-cycle pulse from the UART receiver: a byte is available
- alu_result  in  N  ALU result output (combinational from date_a/date_b/op)
- tx_done  in  1  one-cycle pulse from the UART transmitter: byte sent
- date_a  out  N  registered operand A to the ALU
- date_b  out  N  registered operand B to the ALU
- op  out  N_op  registered opcode to the ALU
- tx_data  out  N  registered byte to the transmitter; valid while tx_start=1, held afterwards
- tx_start  out  1  registered one-cycle request to the transmitter
- busy  out  1  high in S_START and S_WAIT_TX (decoded from state)

## Operation
- FSM states: S_A (reset state), S_B, S_OP, S_START, S_WAIT_TX.
- S_A: on rx_done, date_a <= rx_data, go to S_B.
- S_B: on rx_done, date_b <= rx_data, go to S_OP.
- S_OP: on rx_done, op <= rx_data[N_op-1:0] and go to S_START. Upper bits are discarded.
- S_START: tx_data <= alu_result, tx_start <= 1, go to S_WAIT_TX. This state is unconditional and lasts one cycle.
- S_WAIT_TX: tx_start <= 0. On tx_done, go to S_A.
- rx_done in S_START or S_WAIT_TX: the byte is dropped and no register changes.
- tx_done outside S_WAIT_TX: ignored.
- Opcodes are forwarded unchecked. For an undefined opcode, tx_data captures whatever alu_result presents.
- date_a, date_b and op hold their values between sequences. They are overwritten only by their own byte slot.
- No arithmetic is done here. Widths pass straight through with no sign handling.
- Reset (any state, any cycle): state <= S_A; date_a, date_b, op, tx_data <= 0; tx_start <= 0; busy=0. A partially loaded sequence is abandoned. The next byte received is treated as operand A.

## Timing
- Opcode byte rx_done sampled at edge t:
  - op is updated and state is S_START after t.
  - tx_data and tx_start=1 are visible after edge t+1.
  - tx_start drops after edge t+2.
- The ALU has one full cycle (t to t+1) to settle before capture. The ALU path must meet a single clk period.
- tx_start is exactly one cycle wide, regardless of tx_done timing.
- tx_done is accepted in any S_WAIT_TX cycle, including the first. State is S_A one cycle after tx_done is sampled.
- busy rises one cycle after the opcode rx_done. It falls one cycle after the tx_done that is sampled in S_WAIT_TX.
- Back-to-back rx_done pulses on consecutive cycles in S_A/S_B/S_OP are all accepted.
- Minimum full-sequence throughput: 3 rx cycles + 1 + transmitter time.

## Structure
- Shared package alu_pkg:
  - opcode constants: OP_ADD=32, OP_SUB=34, OP_AND=36, OP_OR=37, OP_XOR=38, OP_SRA=3, OP_SRL=2, OP_NOR=39
  - state encoding for the FSM
- Both the ALU and this controller import alu_pkg.
- No sub-module: a single FSM plus registers.
- The ALU and UART RX/TX are instantiated beside this block at top level, not inside it.

## Test plan
The bench instantiates the real ALU, with alu_result connected.
- Reset: hold reset 2 cycles with rx_done pulsing -> all outputs 0, busy=0, state S_A.
- ADD: bytes 0x05, 0x03, 0x20 -> date_a=0x05, date_b=0x03, op=0x20; tx_data=0x08 with tx_start high exactly one cycle, 2 cycles after the opcode rx_done; busy stays high until tx_done.
- SUB wrap: bytes 0x03, 0x05, 0x22 -> tx_data=0xFE.
- Opcode truncation, NOR: bytes 0xF0, 0x0F, 0xE7 -> op=0x27, tx_data=0x00.
- Drop while busy:
  - send 0xAA during S_WAIT_TX -> date_a unchanged.
  - after tx_done, bytes 0x10, 0x01, 0x02 (SRL) -> tx_data=0x08.
  - a tx_done pulse in S_A causes no state change.
- Reset mid-sequence: after A=0x11 and B=0x22, assert reset one cycle -> all outputs 0; then bytes 0x01, 0x01, 0x20 -> tx_data=0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants and controller state encoding
package alu_pkg;

    localparam int N_DEFAULT    = 8;
    localparam int N_OP_DEFAULT = 6;

    localparam logic [5:0] OP_ADD = 6'd32;
    localparam logic [5:0] OP_SUB = 6'd34;
    localparam logic [5:0] OP_AND = 6'd36;
    localparam logic [5:0] OP_OR  = 6'd37;
    localparam logic [5:0] OP_XOR = 6'd38;
    localparam logic [5:0] OP_SRA = 6'd3;
    localparam logic [5:0] OP_SRL = 6'd2;
    localparam logic [5:0] OP_NOR = 6'd39;

    localparam logic [2:0] S_A       = 3'd0;
    localparam logic [2:0] S_B       = 3'd1;
    localparam logic [2:0] S_OP      = 3'd2;
    localparam logic [2:0] S_START   = 3'd3;
    localparam logic [2:0] S_WAIT_TX = 3'd4;

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// rtl/alu_uart_ctrl_if.sv - UART byte handshakes and registered ALU operand bus
interface alu_uart_ctrl_if #(
    parameter int N    = 8,
    parameter int N_op = 6
);
    logic [N-1:0]    rx_data;
    logic            rx_done;
    logic [N-1:0]    alu_result;
    logic            tx_done;
    logic [N-1:0]    date_a;
    logic [N-1:0]    date_b;
    logic [N_op-1:0] op;
    logic [N-1:0]    tx_data;
    logic            tx_start;
    logic            busy;

    modport master (
        input  rx_data, rx_done, alu_result, tx_done,
        output date_a, date_b, op, tx_data, tx_start, busy
    );

    modport slave (
        output rx_data, rx_done, alu_result, tx_done,
        input  date_a, date_b, op, tx_data, tx_start, busy
    );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU driven by the controller's registered operands
import alu_pkg::*;

module alu #(
    parameter int N    = 8,
    parameter int N_op = 6
) (
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [N_op-1:0] op,
    output logic [N-1:0]    result
);
    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_SRL: result = a >> b;
            OP_SRA: result = $unsigned($signed(a) >>> b);
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/alu_uart_ctrl.sv
// rtl/alu_uart_ctrl.sv - collects A, B, opcode bytes for the ALU and returns its result
import alu_pkg::*;

module alu_uart_ctrl #(
    parameter int N    = 8,
    parameter int N_op = 6
) (
    input  logic             clk,
    input  logic             reset,
    alu_uart_ctrl_if.master  bus
);
    logic [2:0] state;

    assign bus.busy = (state == S_START) || (state == S_WAIT_TX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_A;
            bus.date_a   <= '0;
            bus.date_b   <= '0;
            bus.op       <= '0;
            bus.tx_data  <= '0;
            bus.tx_start <= 1'b0;
        end else begin
            case (state)
                S_A: if (bus.rx_done) begin
                    bus.date_a <= bus.rx_data;
                    state      <= S_B;
                end
                S_B: if (bus.rx_done) begin
                    bus.date_b <= bus.rx_data;
                    state      <= S_OP;
                end
                S_OP: if (bus.rx_done) begin
                    bus.op <= bus.rx_data[N_op-1:0];
                    state  <= S_START;
                end
                // the ALU has had a full cycle on the freshly registered operands
                S_START: begin
                    bus.tx_data  <= bus.alu_result;
                    bus.tx_start <= 1'b1;
                    state        <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    bus.tx_start <= 1'b0;
                    if (bus.tx_done)
                        state <= S_A;
                end
                default: state <= S_A;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb/tb_alu_uart_ctrl.sv - directed self-checking bench for alu_uart_ctrl with the real ALU
module tb_alu_uart_ctrl;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    alu_uart_ctrl_if #(.N(8), .N_op(6)) ifc ();

    alu_uart_ctrl #(.N(8), .N_op(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    alu #(.N(8), .N_op(6)) u_alu (
        .a      (ifc.date_a),
        .b      (ifc.date_b),
        .op     (ifc.op),
        .result (ifc.alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        ifc.rx_data = b;
        ifc.rx_done = 1'b1;
        step();
        ifc.rx_done = 1'b0;
    endtask

    task automatic tx_ack();
        ifc.tx_done = 1'b1;
        step();
        ifc.tx_done = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_date_a"}, ifc.date_a, 8'h00);
        check({tag, "_date_b"}, ifc.date_b, 8'h00);
        check({tag, "_op"}, {2'b00, ifc.op}, 8'h00);
        check({tag, "_tx_data"}, ifc.tx_data, 8'h00);
        check({tag, "_tx_start"}, {7'd0, ifc.tx_start}, 8'h00);
        check({tag, "_busy"}, {7'd0, ifc.busy}, 8'h00);
    endtask

    task automatic run_seq(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] o, input logic [7:0] exp_tx);
        send(a);
        send(b);
        send(o);
        check({tag, "_busy_start"}, {7'd0, ifc.busy}, 8'h01);
        check({tag, "_txs_start"}, {7'd0, ifc.tx_start}, 8'h00);
        step();
        check({tag, "_txs_pulse"}, {7'd0, ifc.tx_start}, 8'h01);
        check({tag, "_tx_data"}, ifc.tx_data, exp_tx);
        step();
        check({tag, "_txs_drop"}, {7'd0, ifc.tx_start}, 8'h00);
        check({tag, "_busy_wait"}, {7'd0, ifc.busy}, 8'h01);
        tx_ack();
        check({tag, "_busy_done"}, {7'd0, ifc.busy}, 8'h00);
        check({tag, "_tx_hold"}, ifc.tx_data, exp_tx);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        ifc.rx_data = 8'h55;
        ifc.rx_done = 1'b1;
        ifc.tx_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset       = 1'b0;
        ifc.rx_done = 1'b0;
        step();

        run_seq("add", 8'h05, 8'h03, 8'h20, 8'h08);
        check("add_date_a", ifc.date_a, 8'h05);
        check("add_date_b", ifc.date_b, 8'h03);
        check("add_op", {2'b00, ifc.op}, 8'h20);

        run_seq("sub", 8'h03, 8'h05, 8'h22, 8'hFE);

        run_seq("nor", 8'hF0, 8'h0F, 8'hE7, 8'h00);
        check("nor_op", {2'b00, ifc.op}, 8'h27);

        // bytes arriving in S_START and S_WAIT_TX must be dropped
        send(8'h07);
        send(8'h01);
        ifc.rx_data = 8'h20;
        ifc.rx_done = 1'b1;
        step();
        ifc.rx_data = 8'hBB;
        step();
        ifc.rx_done = 1'b0;
        check("drop_start_txs", {7'd0, ifc.tx_start}, 8'h01);
        check("drop_start_tx", ifc.tx_data, 8'h08);
        check("drop_start_a", ifc.date_a, 8'h07);
        check("drop_start_b", ifc.date_b, 8'h01);
        send(8'hAA);
        check("drop_wait_a", ifc.date_a, 8'h07);
        check("drop_wait_op", {2'b00, ifc.op}, 8'h20);
        check("drop_wait_busy", {7'd0, ifc.busy}, 8'h01);
        tx_ack();
        check("drop_ack_busy", {7'd0, ifc.busy}, 8'h00);

        run_seq("srl", 8'h10, 8'h01, 8'h02, 8'h08);

        // stray tx_done in S_A: next byte is still operand A
        tx_ack();
        check("stray_busy", {7'd0, ifc.busy}, 8'h00);
        run_seq("stray", 8'h01, 8'h02, 8'h20, 8'h03);
        check("stray_date_a", ifc.date_a, 8'h01);

        send(8'h11);
        send(8'h22);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_zero("midreset");
        run_seq("post", 8'h01, 8'h01, 8'h20, 8'h02);
        check("post_date_a", ifc.date_a, 8'h01);
        check("post_date_b", ifc.date_b, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
